// File: rtl/sync_piso_tx.sv
// Parallel-in/serial-out transmitter: loads a WIDTH-bit word on a valid/ready handshake and shifts it out one bit per enabled clock.
// Latency: first bit visible the cycle after the accepting edge; back-to-back words stream with no idle gap.
// Backpressure: tx_en=0 freezes an in-progress word; in_ready only rises in IDLE or on an enabled last-bit cycle.
module sync_piso_tx #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             tx_en,
    output logic             sout,
    output logic             sout_valid,
    output logic             sout_last,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic             last_bit;
    logic             hs;
    logic [WIDTH-1:0] shreg_shifted;

    assign last_bit = (cnt_q == LAST);

    // The vacated end is always zero-filled so the register drains to 0 on its own.
    assign shreg_shifted = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0}
                                     : {1'b0, shreg_q[WIDTH-1:1]};

    // rst gates in_ready so no word can be accepted while reset is held.
    always_comb begin
        in_ready = 1'b0;
        if (rst) begin
            if (state_q == IDLE) begin
                in_ready = 1'b1;
            end else begin
                in_ready = tx_en && last_bit;
            end
        end
    end

    assign hs = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (hs) begin
                    shreg_d = in;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (tx_en) begin
                    if (!last_bit) begin
                        shreg_d = shreg_shifted;
                        cnt_d   = cnt_q + CW'(1);
                    end else if (in_valid) begin
                        shreg_d = in;
                        cnt_d   = '0;
                    end else begin
                        shreg_d = '0;
                        cnt_d   = '0;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                shreg_d = '0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        busy       = (state_q == SHIFT);
        sout_valid = busy;
        sout_last  = busy && last_bit;
        sout       = 1'b0;
        if (busy) begin
            sout = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
        end
    end

endmodule

// File: tb/tb_sync_piso_tx.sv
// Directed bench for sync_piso_tx: one MSB-first and one LSB-first instance sharing clock, reset and tx_en.
module tb_sync_piso_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tx_en = 1'b1;
    logic [3:0] din = 4'b0000;
    logic       din_vld = 1'b0;
    logic       in_ready, sout, sout_valid, sout_last, busy;
    logic [3:0] din_l = 4'b0000;
    logic       din_vld_l = 1'b0;
    logic       in_ready_l, sout_l, sout_valid_l, sout_last_l, busy_l;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    always #5 clk = ~clk;

    sync_piso_tx #(.WIDTH(4), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst(rst), .in(din), .in_valid(din_vld), .in_ready(in_ready),
        .tx_en(tx_en), .sout(sout), .sout_valid(sout_valid), .sout_last(sout_last), .busy(busy)
    );

    sync_piso_tx #(.WIDTH(4), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst(rst), .in(din_l), .in_valid(din_vld_l), .in_ready(in_ready_l),
        .tx_en(tx_en), .sout(sout_l), .sout_valid(sout_valid_l), .sout_last(sout_last_l), .busy(busy_l)
    );

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; din_vld = 1'b1; din = 4'b1111; din_vld_l = 1'b1; din_l = 4'b1111;
        for (int i = 0; i < 2; i++) begin
            step();
            chk_cnt++; if (sout_valid !== 1'b0) $display("FAIL reset_sout_valid[%0d] got %b want 0", i, sout_valid); else pass_cnt++;
            chk_cnt++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready[%0d] got %b want 0", i, in_ready); else pass_cnt++;
            chk_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy[%0d] got %b want 0", i, busy); else pass_cnt++;
            chk_cnt++; if (sout !== 1'b0) $display("FAIL reset_sout[%0d] got %b want 0", i, sout); else pass_cnt++;
            chk_cnt++; if (in_ready_l !== 1'b0) $display("FAIL reset_in_ready_lsb[%0d] got %b want 0", i, in_ready_l); else pass_cnt++;
        end
        din_vld = 1'b0; din_vld_l = 1'b0; rst = 1'b1;
        step();
        chk_cnt++; if (in_ready !== 1'b1) $display("FAIL idle_in_ready got %b want 1", in_ready); else pass_cnt++;
        chk_cnt++; if (busy !== 1'b0) $display("FAIL idle_busy got %b want 0", busy); else pass_cnt++;
        chk_cnt++; if (sout_valid !== 1'b0) $display("FAIL idle_sout_valid got %b want 0", sout_valid); else pass_cnt++;
        chk_cnt++; if (busy_l !== 1'b0) $display("FAIL idle_busy_lsb got %b want 0", busy_l); else pass_cnt++;
    endtask

    task automatic test_single_word();
        logic [3:0] exp_w;
        exp_w = 4'b1010;
        tx_en = 1'b1; din = 4'b1010; din_vld = 1'b1;
        step();
        din_vld = 1'b0; din = 4'b0110;
        for (int i = 0; i < 4; i++) begin
            chk_cnt++; if (sout !== exp_w[3-i]) $display("FAIL single_sout[%0d] got %b want %b", i, sout, exp_w[3-i]); else pass_cnt++;
            chk_cnt++; if (sout_valid !== 1'b1) $display("FAIL single_valid[%0d] got %b want 1", i, sout_valid); else pass_cnt++;
            chk_cnt++; if (sout_last !== (i == 3)) $display("FAIL single_last[%0d] got %b want %b", i, sout_last, (i == 3)); else pass_cnt++;
            chk_cnt++; if (busy !== 1'b1) $display("FAIL single_busy[%0d] got %b want 1", i, busy); else pass_cnt++;
            step();
        end
        chk_cnt++; if (sout_valid !== 1'b0) $display("FAIL single_end_valid got %b want 0", sout_valid); else pass_cnt++;
        chk_cnt++; if (busy !== 1'b0) $display("FAIL single_end_busy got %b want 0", busy); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_s;
        exp_s = 8'b1001_1110;
        tx_en = 1'b1; din = 4'b1001; din_vld = 1'b1;
        step();
        for (int i = 0; i < 8; i++) begin
            if (i == 3) din = 4'b1110;
            if (i == 7) din_vld = 1'b0;
            #0;
            chk_cnt++; if (sout !== exp_s[7-i]) $display("FAIL b2b_sout[%0d] got %b want %b", i, sout, exp_s[7-i]); else pass_cnt++;
            chk_cnt++; if (sout_valid !== 1'b1) $display("FAIL b2b_valid[%0d] got %b want 1", i, sout_valid); else pass_cnt++;
            chk_cnt++; if (sout_last !== (i == 3 || i == 7)) $display("FAIL b2b_last[%0d] got %b want %b", i, sout_last, (i == 3 || i == 7)); else pass_cnt++;
            chk_cnt++; if (in_ready !== (i == 3 || i == 7)) $display("FAIL b2b_in_ready[%0d] got %b want %b", i, in_ready, (i == 3 || i == 7)); else pass_cnt++;
            step();
        end
        chk_cnt++; if (sout_valid !== 1'b0) $display("FAIL b2b_end_valid got %b want 0", sout_valid); else pass_cnt++;
    endtask

    task automatic test_stall();
        logic [6:0] en_v, exp_o, exp_l, exp_r;
        // Index i (bit 6-i) is cycle i after the load edge.
        en_v  = 7'b1000111;
        exp_o = 7'b0000010;
        exp_l = 7'b0000001;
        exp_r = 7'b0000001;
        tx_en = 1'b1; din = 4'b0010; din_vld = 1'b1;
        step();
        din_vld = 1'b0;
        for (int i = 0; i < 7; i++) begin
            tx_en = en_v[6-i];
            #0;
            chk_cnt++; if (sout !== exp_o[6-i]) $display("FAIL stall_sout[%0d] got %b want %b", i, sout, exp_o[6-i]); else pass_cnt++;
            chk_cnt++; if (sout_valid !== 1'b1) $display("FAIL stall_valid[%0d] got %b want 1", i, sout_valid); else pass_cnt++;
            chk_cnt++; if (sout_last !== exp_l[6-i]) $display("FAIL stall_last[%0d] got %b want %b", i, sout_last, exp_l[6-i]); else pass_cnt++;
            chk_cnt++; if (in_ready !== exp_r[6-i]) $display("FAIL stall_in_ready[%0d] got %b want %b", i, in_ready, exp_r[6-i]); else pass_cnt++;
            step();
        end
        tx_en = 1'b1;
        chk_cnt++; if (sout_valid !== 1'b0) $display("FAIL stall_end_valid got %b want 0", sout_valid); else pass_cnt++;
    endtask

    task automatic test_reset_mid_word();
        logic [3:0] exp_w;
        tx_en = 1'b1; din = 4'b1000; din_vld = 1'b1;
        step();
        din_vld = 1'b0;
        chk_cnt++; if (sout !== 1'b1) $display("FAIL midrst_bit1 got %b want 1", sout); else pass_cnt++;
        chk_cnt++; if (sout_last !== 1'b0) $display("FAIL midrst_last1 got %b want 0", sout_last); else pass_cnt++;
        step();
        chk_cnt++; if (sout !== 1'b0) $display("FAIL midrst_bit2 got %b want 0", sout); else pass_cnt++;
        chk_cnt++; if (sout_last !== 1'b0) $display("FAIL midrst_last2 got %b want 0", sout_last); else pass_cnt++;
        rst = 1'b0;
        step();
        chk_cnt++; if (sout_valid !== 1'b0) $display("FAIL midrst_valid got %b want 0", sout_valid); else pass_cnt++;
        chk_cnt++; if (sout_last !== 1'b0) $display("FAIL midrst_last got %b want 0", sout_last); else pass_cnt++;
        chk_cnt++; if (in_ready !== 1'b0) $display("FAIL midrst_in_ready got %b want 0", in_ready); else pass_cnt++;
        rst = 1'b1;
        step();
        chk_cnt++; if (sout_valid !== 1'b0) $display("FAIL midrst_idle_valid got %b want 0", sout_valid); else pass_cnt++;
        exp_w = 4'b0001;
        din = 4'b0001; din_vld = 1'b1;
        step();
        din_vld = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk_cnt++; if (sout !== exp_w[3-i]) $display("FAIL midrst_new_sout[%0d] got %b want %b", i, sout, exp_w[3-i]); else pass_cnt++;
            chk_cnt++; if (sout_valid !== 1'b1) $display("FAIL midrst_new_valid[%0d] got %b want 1", i, sout_valid); else pass_cnt++;
            chk_cnt++; if (sout_last !== (i == 3)) $display("FAIL midrst_new_last[%0d] got %b want %b", i, sout_last, (i == 3)); else pass_cnt++;
            step();
        end
        chk_cnt++; if (sout_valid !== 1'b0) $display("FAIL midrst_new_end got %b want 0", sout_valid); else pass_cnt++;
    endtask

    task automatic test_lsb_first();
        logic [3:0] exp_o;
        exp_o = 4'b0001;
        // Load while tx_en is low; the first bit must wait for tx_en.
        tx_en = 1'b0; din_l = 4'b1000; din_vld_l = 1'b1;
        #0;
        chk_cnt++; if (in_ready_l !== 1'b1) $display("FAIL lsb_idle_ready got %b want 1", in_ready_l); else pass_cnt++;
        step();
        din_vld_l = 1'b0; din_l = 4'b1111;
        chk_cnt++; if (sout_valid_l !== 1'b1) $display("FAIL lsb_hold_valid got %b want 1", sout_valid_l); else pass_cnt++;
        chk_cnt++; if (in_ready_l !== 1'b0) $display("FAIL lsb_hold_ready got %b want 0", in_ready_l); else pass_cnt++;
        step();
        tx_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk_cnt++; if (sout_l !== exp_o[3-i]) $display("FAIL lsb_sout[%0d] got %b want %b", i, sout_l, exp_o[3-i]); else pass_cnt++;
            chk_cnt++; if (sout_valid_l !== 1'b1) $display("FAIL lsb_valid[%0d] got %b want 1", i, sout_valid_l); else pass_cnt++;
            chk_cnt++; if (sout_last_l !== (i == 3)) $display("FAIL lsb_last[%0d] got %b want %b", i, sout_last_l, (i == 3)); else pass_cnt++;
            step();
        end
        chk_cnt++; if (busy_l !== 1'b0) $display("FAIL lsb_end_busy got %b want 0", busy_l); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_stall();
        test_reset_mid_word();
        test_lsb_first();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
